// File: rtl/ps2_pkg.sv
// Shared PS/2 decode definitions: parser state encoding, protocol
// byte constants, key code width and a helper for ignored bytes.
package ps2_pkg;

   localparam int KEY_W = 9;

   localparam logic [7:0] B_00 = 8'h00;
   localparam logic [7:0] B_AA = 8'hAA;
   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_E1 = 8'hE1;
   localparam logic [7:0] B_F0 = 8'hF0;
   localparam logic [7:0] B_FA = 8'hFA;
   localparam logic [7:0] B_FE = 8'hFE;
   localparam logic [7:0] B_FF = 8'hFF;

   localparam logic [2:0] SKIP_LEN = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } ps2_state_t;

   // Self-test, ack, resend and error bytes never start a key sequence.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == B_00) || (b == B_AA) || (b == B_FA) ||
             (b == B_FE) || (b == B_FF);
   endfunction

   // Next state for a byte decoded from IDLE (also used on restart).
   function automatic ps2_state_t idle_next(input logic [7:0] b);
      if (b == B_E0) return ST_EXT;
      if (b == B_F0) return ST_BRK;
      if (b == B_E1) return ST_SKIP;
      return ST_IDLE;
   endfunction

endpackage

// File: rtl/ps2_scancode_parser.sv
// PS/2 set-2 sequence parser: folds E0/F0/E1 prefixes into 9-bit codes.
// Ports: Clock, reset (async low), rx_data/rx_valid in; code_o, brk_o,
// done_o (same-cycle decode of the completing byte), seq_error_o
// (registered pulse). Optional macro PS2_SEQ_TIMEOUT_EN adds a
// partial-sequence timeout.
module ps2_scancode_parser
   import ps2_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 25000000,
   parameter int TIMEOUT_MS      = 2
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [KEY_W-1:0] code_o,
   output logic             brk_o,
   output logic             done_o,
   output logic             seq_error_o
);

   ps2_state_t state_q;
   logic [2:0] skip_q;
   logic       seq_error_q;

`ifdef PS2_SEQ_TIMEOUT_EN
   localparam int TMO_CYCLES = CLOCK_FREQUENCY / 1000 * TIMEOUT_MS;
   logic [31:0] tmo_q;
`endif

   logic is_pfx;
   assign is_pfx = (rx_data == B_E0) || (rx_data == B_F0);

   // Decode is combinational so the key table can register the result
   // on the same edge that consumes the completing byte.
   always_comb begin
      done_o = 1'b0;
      brk_o  = 1'b0;
      code_o = '0;
      if (rx_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!is_pfx && rx_data != B_E1 && !is_ignored(rx_data)) begin
                  done_o = 1'b1;
                  code_o = {1'b0, rx_data};
               end
            end
            ST_EXT: begin
               if (!is_pfx) begin
                  done_o = 1'b1;
                  code_o = {1'b1, rx_data};
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               if (!is_pfx) begin
                  done_o = 1'b1;
                  brk_o  = 1'b1;
                  code_o = {state_q == ST_EXT_BRK, rx_data};
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         skip_q      <= '0;
         seq_error_q <= 1'b0;
`ifdef PS2_SEQ_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         seq_error_q <= 1'b0;
         if (rx_valid) begin
            unique case (state_q)
               ST_IDLE: begin
                  state_q <= idle_next(rx_data);
                  if (rx_data == B_E1) skip_q <= SKIP_LEN;
               end
               ST_EXT: begin
                  if (rx_data == B_F0) begin
                     state_q <= ST_EXT_BRK;
                  end else if (rx_data == B_E0) begin
                     seq_error_q <= 1'b1;
                     state_q     <= ST_EXT;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_BRK, ST_EXT_BRK: begin
                  // A stray prefix aborts and restarts the sequence.
                  if (is_pfx) seq_error_q <= 1'b1;
                  state_q <= idle_next(rx_data);
               end
               ST_SKIP: begin
                  if (skip_q <= 3'd1) begin
                     skip_q  <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     skip_q <= skip_q - 3'd1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
`ifdef PS2_SEQ_TIMEOUT_EN
         if (rx_valid || state_q == ST_IDLE) begin
            tmo_q <= '0;
         end else if (tmo_q == 32'(TMO_CYCLES - 1)) begin
            tmo_q       <= '0;
            skip_q      <= '0;
            state_q     <= ST_IDLE;
            seq_error_q <= 1'b1;
         end else begin
            tmo_q <= tmo_q + 32'd1;
         end
`endif
      end
   end

   assign seq_error_o = seq_error_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Held-key table fed by ps2_scancode_parser: tracks up to MAX_KEYS
// pressed keys, reports make/break/repeat events and overflow.
// Ports: Clock, reset (async low), rx_data, rx_valid, key_clear in;
// held_valid, held_keys, newest_key, key_event, event_code,
// event_break, event_repeat, overflow, seq_error out.
// Macro PS2_SEQ_TIMEOUT_EN enables the parser timeout.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 25000000,
   parameter int MAX_KEYS        = 4,
   parameter int TIMEOUT_MS      = 2
) (
   input  logic                      Clock,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   input  logic                      key_clear,
   output logic [MAX_KEYS-1:0]       held_valid,
   output logic [KEY_W*MAX_KEYS-1:0] held_keys,
   output logic [KEY_W-1:0]          newest_key,
   output logic                      key_event,
   output logic [KEY_W-1:0]          event_code,
   output logic                      event_break,
   output logic                      event_repeat,
   output logic                      overflow,
   output logic                      seq_error
);

   logic [KEY_W-1:0] code;
   logic             brk;
   logic             done;

   ps2_scancode_parser #(
      .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
      .TIMEOUT_MS     (TIMEOUT_MS)
   ) u_parser (
      .Clock      (Clock),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .code_o     (code),
      .brk_o      (brk),
      .done_o     (done),
      .seq_error_o(seq_error)
   );

   logic [MAX_KEYS-1:0] valid_q;
   logic [KEY_W-1:0]    keys_q [MAX_KEYS];
   logic [KEY_W-1:0]    newest_q;
   logic [KEY_W-1:0]    ev_code_q;
   logic                ev_q;
   logic                ev_brk_q;
   logic                ev_rep_q;
   logic                ovf_q;

   logic [MAX_KEYS-1:0] hit_vec;
   logic [MAX_KEYS-1:0] free_oh;
   logic                hit;
   logic                full;
   logic                found;

   // Match vector and one-hot lowest free slot.
   always_comb begin
      hit_vec = '0;
      free_oh = '0;
      found   = 1'b0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         hit_vec[i] = valid_q[i] && (keys_q[i] == code);
         if (!valid_q[i] && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign hit  = |hit_vec;
   assign full = &valid_q;

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         for (int i = 0; i < MAX_KEYS; i++) keys_q[i] <= '0;
         newest_q  <= '0;
         ev_code_q <= '0;
         ev_q      <= 1'b0;
         ev_brk_q  <= 1'b0;
         ev_rep_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         ev_q <= done;
         if (done) begin
            ev_code_q <= code;
            ev_brk_q  <= brk;
            ev_rep_q  <= !brk && hit;
         end
         // A flush overrides any table update from the same byte.
         if (key_clear) begin
            valid_q  <= '0;
            for (int i = 0; i < MAX_KEYS; i++) keys_q[i] <= '0;
            newest_q <= '0;
            ovf_q    <= 1'b0;
         end else if (done) begin
            if (brk) begin
               for (int i = 0; i < MAX_KEYS; i++) begin
                  if (hit_vec[i]) begin
                     valid_q[i] <= 1'b0;
                     keys_q[i]  <= '0;
                  end
               end
               if (newest_q == code) newest_q <= '0;
            end else if (!hit) begin
               if (full) begin
                  ovf_q <= 1'b1;
               end else begin
                  for (int i = 0; i < MAX_KEYS; i++) begin
                     if (free_oh[i]) begin
                        valid_q[i] <= 1'b1;
                        keys_q[i]  <= code;
                     end
                  end
                  newest_q <= code;
               end
            end
         end
      end
   end

   always_comb begin
      held_keys = '0;
      for (int i = 0; i < MAX_KEYS; i++)
         held_keys[KEY_W*i +: KEY_W] = keys_q[i];
   end

   assign held_valid   = valid_q;
   assign newest_key   = newest_q;
   assign key_event    = ev_q;
   assign event_code   = ev_code_q;
   assign event_break  = ev_brk_q;
   assign event_repeat = ev_rep_q;
   assign overflow     = ovf_q;

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter CLOCK_FREQUENCY, 25000000, Clock rate in Hz; used only for the timeout count.
REQ-002 Parameter MAX_KEYS, 4, number of simultaneously held keys tracked (1..16).
REQ-003 Parameter TIMEOUT_MS, 2, partial-sequence timeout in milliseconds.
REQ-004 Clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  received PS/2 byte, from the PS2_Controller received_data output.
REQ-007 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 key_clear  input  1  synchronous flush of the held-key table.
REQ-009 held_valid  output  MAX_KEYS  per-slot occupied flag.
REQ-010 held_keys  output  9*MAX_KEYS  slot i at bits [9i+8:9i]; bit 8 = E0-extended, bits 7:0 = scancode.
REQ-011 newest_key  output  9  most recently inserted key, 0 when none.
REQ-012 key_event  output  1  one-cycle pulse per completed make/break sequence.
REQ-013 event_code  output  9  code of the last event; holds until the next event.
REQ-014 event_break  output  1  1 = release, 0 = press; valid with key_event.
REQ-015 event_repeat  output  1  press of an already-held key (typematic); valid with key_event.
REQ-016 overflow  output  1  sticky: a press was dropped because the table was full.
REQ-017 seq_error  output  1  one-cycle pulse on a discarded partial sequence.

Function
REQ-018 Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (pause sequence).
REQ-019 IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with a counter loaded to 7; 00, AA, FA, FE and FF are ignored; any other byte is a make with bit 8 = 0.
REQ-020 EXT: F0 -> EXT_BRK; any other byte is a make with bit 8 = 1 and returns to IDLE.
REQ-021 BRK and EXT_BRK: the next byte is a break with bit 8 = 0 or 1 respectively; return to IDLE.
REQ-022 SKIP: each rx_valid decrements the counter; return to IDLE after the 7th byte; no events are produced.
REQ-023 An E0 byte in EXT, or an E0/F0 byte in BRK or EXT_BRK, pulses seq_error and restarts decoding with that byte as if in IDLE.
REQ-024 Make of a code not held: insert it into the lowest-index free slot, set newest_key, pulse key_event with event_repeat = 0.
REQ-025 Make of a code already held: leave the table unchanged, pulse key_event with event_repeat = 1.
REQ-026 Make with the table full: set overflow, pulse key_event, leave the table unchanged.
REQ-027 Break: clear the matching slot if present, then pulse key_event with event_break = 1; if newest_key equals the code, set newest_key to 0.
REQ-028 Slots never compact; surviving keys keep their index.
REQ-029 Latency: the table, newest_key and all event outputs update in the cycle after the rx_valid that completes a sequence.
REQ-030 key_clear asserted together with a completing rx_valid: the clear wins, the event still pulses, and the table ends empty; key_clear also clears overflow and newest_key.

Reset
REQ-031 On reset low, asynchronously: FSM to IDLE, SKIP counter 0, all slots invalid and 0, newest_key 0, event_code 0, all pulses and flags 0, timeout counter 0.
REQ-032 Reset asserted mid-sequence discards the partial sequence without pulsing seq_error.

Configuration
REQ-033 With PS2_SEQ_TIMEOUT_EN defined: in any state other than IDLE, if no rx_valid arrives for CLOCK_FREQUENCY/1000*TIMEOUT_MS cycles, the FSM returns to IDLE and pulses seq_error once.
REQ-034 With PS2_SEQ_TIMEOUT_EN undefined: no timeout counter exists and the FSM waits indefinitely.

Structure
REQ-035 Shared package ps2_pkg holds the state encoding and the byte constants E0, E1, F0, AA, FA, FE, plus the 9-bit key width constant.
REQ-036 Sub-module ps2_scancode_parser contains the FSM and timeout and outputs a code, break and complete strobe; ps2_key_tracker contains the slot table.

Verification
REQ-037 Stimulus 1C -> slot0 = 0x01C, newest = 0x01C, event_break 0, event_repeat 0. Then F0 1C -> slot0 invalid, newest 0, event_break 1.
REQ-038 Stimulus E0 75, 1C, E0 F0 75 -> slot0 = 0x175 then cleared, slot1 = 0x01C retained, newest = 0x01C.
REQ-039 With MAX_KEYS = 4, press 1C, 1B, 23, 2B, 29 -> overflow = 1 and 29 is absent. Then press 1C again -> event_repeat = 1 and the table is unchanged.
REQ-040 Stimulus E1 14 77 E1 F0 14 F0 77 -> no key_event and the table is empty. Stimulus AA -> no event.
REQ-041 With the macro defined, send F0, then idle 50001 cycles at 25 MHz -> seq_error pulses once. Then send 1C -> a make of 0x01C, not a break.
REQ-042 Drive reset low asynchronously between E0 and 75 -> all outputs return to 0. A following 75 decodes as 0x075.
